// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/valid handshake and operand/result bundle for seq_divider
interface seq_divider_if #(
   parameter int DATA_W = 32
);
   logic              i_start;
   logic              i_signed;
   logic [DATA_W-1:0] i_dividend;
   logic [DATA_W-1:0] i_divisor;
   logic              o_ready;
   logic              o_busy;
   logic              o_valid;
   logic [DATA_W-1:0] o_quotient;
   logic [DATA_W-1:0] o_remainder;
   logic              o_div_by_zero;

   modport master (
      output i_start, i_signed, i_dividend, i_divisor,
      input  o_ready, o_busy, o_valid, o_quotient, o_remainder, o_div_by_zero
   );

   modport slave (
      input  i_start, i_signed, i_dividend, i_divisor,
      output o_ready, o_busy, o_valid, o_quotient, o_remainder, o_div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider for DIV/DIVU/REM/REMU
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC.
module seq_divider #(
   parameter int DATA_W = 32
) (
   input  logic          i_clk,
   input  logic          i_reset,
   seq_divider_if.slave  bus
);
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] qr_q, qr_d;
   logic [DATA_W-1:0] dvs_q, dvs_d;
   logic [DATA_W-1:0] dvd_q, dvd_d;
   logic              signed_q, signed_d;
   logic              a_neg_q, a_neg_d;
   logic              b_neg_q, b_neg_d;
   logic              dz_q, dz_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] quot_q, quot_d;
   logic [DATA_W-1:0] rmd_q, rmd_d;
   logic              dbz_q, dbz_d;

   logic [DATA_W:0]   r_shift;
   logic [DATA_W:0]   sub_w;
   logic              t_nonneg;
   logic              in_dz, in_ovf;
   logic [DATA_W-1:0] q_fix, r_fix;

   // The partial remainder never reaches the divisor, so its top (W+1th) bit is
   // always zero and only W bits are stored; R' keeps the shifted-out bit.
   always_comb begin
      r_shift  = {rem_q, qr_q[DATA_W-1]};
      sub_w    = {1'b0, r_shift[DATA_W-1:0]} + {1'b0, ~dvs_q} + {{DATA_W{1'b0}}, 1'b1};
      t_nonneg = r_shift[DATA_W] | sub_w[DATA_W];
      in_dz    = ~|bus.i_divisor;
      in_ovf   = bus.i_signed & (bus.i_dividend == MIN_NEG) & (&bus.i_divisor);
      q_fix    = (signed_q & (a_neg_q ^ b_neg_q)) ? -qr_q : qr_q;
      r_fix    = (signed_q & a_neg_q) ? -rem_q : rem_q;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      qr_d     = qr_q;
      dvs_d    = dvs_q;
      dvd_d    = dvd_q;
      signed_d = signed_q;
      a_neg_d  = a_neg_q;
      b_neg_d  = b_neg_q;
      dz_d     = dz_q;
      ovf_d    = ovf_q;
      quot_d   = quot_q;
      rmd_d    = rmd_q;
      dbz_d    = dbz_q;
      case (state_q)
         IDLE: begin
            if (bus.i_start) begin
               signed_d = bus.i_signed;
               a_neg_d  = bus.i_signed & bus.i_dividend[DATA_W-1];
               b_neg_d  = bus.i_signed & bus.i_divisor[DATA_W-1];
               qr_d     = (bus.i_signed & bus.i_dividend[DATA_W-1]) ? -bus.i_dividend : bus.i_dividend;
               dvs_d    = (bus.i_signed & bus.i_divisor[DATA_W-1]) ? -bus.i_divisor : bus.i_divisor;
               dvd_d    = bus.i_dividend;
               dz_d     = in_dz;
               ovf_d    = in_ovf;
               rem_d    = '0;
               cnt_d    = '0;
               state_d  = CALC;
`ifdef DIV_EARLY_OUT_EN
               if (in_dz || in_ovf) begin
                  state_d = FIX;
               end
`endif
            end
         end
         CALC: begin
            rem_d = t_nonneg ? sub_w[DATA_W-1:0] : r_shift[DATA_W-1:0];
            qr_d  = {qr_q[DATA_W-2:0], t_nonneg};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W-1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            dbz_d = dz_q;
            if (dz_q) begin
               quot_d = '1;
               rmd_d  = dvd_q;
            end else if (ovf_q) begin
               quot_d = dvd_q;
               rmd_d  = '0;
            end else begin
               quot_d = q_fix;
               rmd_d  = r_fix;
            end
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         qr_q     <= '0;
         dvs_q    <= '0;
         dvd_q    <= '0;
         signed_q <= 1'b0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         quot_q   <= '0;
         rmd_q    <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         qr_q     <= qr_d;
         dvs_q    <= dvs_d;
         dvd_q    <= dvd_d;
         signed_q <= signed_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
         dz_q     <= dz_d;
         ovf_q    <= ovf_d;
         quot_q   <= quot_d;
         rmd_q    <= rmd_d;
         dbz_q    <= dbz_d;
      end
   end

   assign bus.o_ready       = (state_q == IDLE);
   assign bus.o_busy        = (state_q == CALC) || (state_q == FIX);
   assign bus.o_valid       = (state_q == DONE);
   assign bus.o_quotient    = quot_q;
   assign bus.o_remainder   = rmd_q;
   assign bus.o_div_by_zero = dbz_q;
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU path; sits downstream of the ALU operand muxes.
- Performs one trial subtraction per cycle: W-bit subtract, carry-in 1, operand inverted.
- Returns registered quotient and remainder with a start/valid handshake.
- Keeps the single-cycle datapath short by taking division out of the combinational ALU.

Parameters:
- DATA_W, 32, operand/result width in bits (even, >= 4)

Ports:
- i_clk  input  1  clock, rising edge
- i_reset  input  1  asynchronous active-high reset
- i_start  input  1  start request; accepted only when o_ready=1
- i_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with i_start
- i_dividend  input  DATA_W  dividend; sampled with i_start
- i_divisor  input  DATA_W  divisor; sampled with i_start
- o_ready  output  1  1 in IDLE only
- o_busy  output  1  1 in CALC or FIX
- o_valid  output  1  one-cycle pulse, high in DONE
- o_quotient  output  DATA_W  registered quotient, held until next result
- o_remainder  output  DATA_W  registered remainder, held until next result
- o_div_by_zero  output  1  registered flag, divisor was 0; updated with results

Behaviour:
- Clock and reset: one clock i_clk; reset i_reset is asynchronous, active-high.
- Reset:
  - state=IDLE.
  - o_quotient, o_remainder, o_div_by_zero, o_valid, o_busy = 0; o_ready=1.
  - Internal counter, registers and sign flags = 0.
  - Reset asserted in any state aborts the operation; no o_valid is produced.
- FSM, IDLE -> CALC -> FIX -> DONE -> IDLE:
  - IDLE: on edge E0 with i_start=1, latch operands, i_signed and sign flags; go to CALC.
    - Signed mode: latch magnitudes of both operands; -2^(W-1) maps to itself as unsigned.
    - Partial remainder R (DATA_W+1 bits) = 0; counter = 0.
  - CALC: edges E1..E_W each do one iteration, then go to FIX on E_W.
    - R' = {R[W-1:0], Qreg msb}; shift Qreg left.
    - T = R' - {0,divisor}.
    - If T is non-negative (carry out = 1): R=T and set the Qreg lsb. Otherwise R=R' and clear the Qreg lsb.
  - FIX: edge E_{W+1} registers the corrected results into the outputs and goes to DONE.
    - Quotient is negated if the signs differ (signed mode).
    - Remainder takes the dividend sign (signed mode).
    - Overrides applied here:
      - Divisor 0: q = all ones, r = dividend, o_div_by_zero = 1.
      - Signed -2^(W-1) / -1: q = dividend, r = 0.
  - DONE: o_valid=1 for exactly one cycle; next edge returns to IDLE.
- Latency: o_valid is high in the cycle after edge E_{W+1}, i.e. W+1 edges after acceptance (33 for W=32).
- i_start outside IDLE is ignored. No queueing, and latched operands are not disturbed.
- Operand inputs may change freely after E0.
- Outputs hold their values through IDLE until the next FIX edge.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE on E0, divide-by-zero or signed overflow goes directly to FIX.
  - Override results are written on E1; o_valid is high after E1 (latency 1).
  - Normal operations are unchanged (W+1).
- Undefined: all operations take W+1 edges; overrides are applied only in FIX.

Test Plan:
- Unsigned, W=32: dividend 100, divisor 7 -> q=14, r=2, div_by_zero=0; o_valid after exactly 33 edges; o_busy high for 33 cycles.
- Signed: dividend -7 (0xFFFFFFF9), divisor 2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Also 7 / -2 -> q=-3, r=1.
- Divide by zero, unsigned: 0x00001234 / 0 -> q=0xFFFFFFFF, r=0x00001234, div_by_zero=1; latency 33, or 1 with DIV_EARLY_OUT_EN.
- Signed overflow: 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, div_by_zero=0; latency 33, or 1 with the macro.
- Start ignored while busy: i_start=1 with new operands at cycle 5 of CALC -> first result is unaffected, no second o_valid. Next start after o_ready=1 -> correct new result.
- Reset mid-operation: assert i_reset asynchronously at cycle 10 of CALC -> immediately o_busy=0, o_ready=1, outputs=0, no o_valid. A fresh 100/7 afterwards -> q=14, r=2.
